// File: rtl/cv_pkg.sv
// Shared definitions for the cv render-path scheduler blocks.
package cv_pkg;

  // Scheduler states, one per scanline phase
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_RENDER = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/cv_satcnt.sv
// Saturating up-counter with synchronous clear; an increment in the same
// cycle as a clear counts from zero, so the result is 1.
module cv_satcnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_base;

  assign w_base = i_clr ? '0 : r_cnt;

  // Count up from the (possibly cleared) base, sticking at all-ones
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= (&w_base) ? w_base : w_base + 1'b1;
    end else if (i_clr) begin
      r_cnt <= '0;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cv_lbsched.sv
// Per-scanline scheduler: swaps the ping-pong line buffers on each line
// start, clears the back buffer, then requests rendering from cv_rdctrl
// until it reports completion. Lines that miss their deadline are counted.
module cv_lbsched
  import cv_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int LINE_PIX = 320,
  parameter int OVR_W    = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_frame_start,
  input  logic              i_hstart,
  input  logic              i_rend_line,
  input  logic              i_rd_done,
  input  logic              i_ovr_clr,
  output logic              o_rd_cs,
  output logic              o_lb_sel,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_busy,
  output logic              o_ovr_flag,
  output logic [OVR_W-1:0]  o_ovr_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_PIX - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic              w_ovr;
  logic              r_rd_cs;
  logic              r_clr_we;
  logic              r_busy;
  logic              r_lb_sel;
  logic              r_ovr_flag;

  // Next state, next clear address and overrun detection
  always_comb begin
    w_next      = r_state;
    w_next_addr = r_clr_addr;
    w_ovr       = 1'b0;
    if (!i_enable) begin
      w_next      = ST_IDLE;
      w_next_addr = '0;
    end else if (i_hstart) begin
      w_next      = i_rend_line ? ST_CLEAR : ST_IDLE;
      w_next_addr = '0;
      w_ovr       = (r_state == ST_CLEAR) ||
                    ((r_state == ST_RENDER) && !i_rd_done);
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            w_next      = ST_RENDER;
            w_next_addr = '0;
          end else begin
            w_next_addr = r_clr_addr + 1'b1;
          end
        end
        ST_RENDER: begin
          if (i_rd_done) begin
            w_next = ST_HOLD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State register plus outputs registered from the state being entered
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_clr_addr <= '0;
      r_rd_cs    <= 1'b0;
      r_clr_we   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_clr_addr <= w_next_addr;
      r_rd_cs    <= (w_next == ST_RENDER);
      r_clr_we   <= (w_next == ST_CLEAR);
      r_busy     <= (w_next == ST_CLEAR) || (w_next == ST_RENDER);
    end
  end

  // Buffer swap on each line start; frame start re-aligns to buffer 0
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lb_sel <= 1'b0;
    end else if (i_enable) begin
      if (i_frame_start) begin
        r_lb_sel <= 1'b0;
      end else if (i_hstart) begin
        r_lb_sel <= ~r_lb_sel;
      end
    end
  end

  // Sticky overrun flag; a new overrun beats a clear in the same cycle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ovr_flag <= 1'b0;
    end else if (w_ovr) begin
      r_ovr_flag <= 1'b1;
    end else if (i_ovr_clr) begin
      r_ovr_flag <= 1'b0;
    end
  end

  cv_satcnt #(
    .W (OVR_W)
  ) u_ovr_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_reset_n),
    .i_clr   (i_ovr_clr),
    .i_inc   (w_ovr),
    .o_cnt   (o_ovr_cnt)
  );

  assign o_rd_cs    = r_rd_cs;
  assign o_clr_we   = r_clr_we;
  assign o_clr_addr = r_clr_addr;
  assign o_busy     = r_busy;
  assign o_lb_sel   = r_lb_sel;
  assign o_ovr_flag = r_ovr_flag;

endmodule

// File: tb/tb_cv_lbsched.sv
// Self-checking bench for cv_lbsched: directed scenarios followed by random
// line traffic, all compared against a line-timing reference model.
module tb_cv_lbsched;

  localparam int ADDR_W   = 9;
  localparam int LINE_PIX = 320;
  localparam int OVR_W    = 8;
  localparam int CNT_MAX  = (1 << OVR_W) - 1;
  localparam int NEVER    = 32'h7fffffff;

  localparam int PH_IDLE   = 0;
  localparam int PH_CLEAR  = 1;
  localparam int PH_RENDER = 2;
  localparam int PH_HOLD   = 3;

  logic              i_clk;
  logic              i_reset_n;
  logic              i_enable;
  logic              i_frame_start;
  logic              i_hstart;
  logic              i_rend_line;
  logic              i_rd_done;
  logic              i_ovr_clr;
  logic              o_rd_cs;
  logic              o_lb_sel;
  logic              o_clr_we;
  logic [ADDR_W-1:0] o_clr_addr;
  logic              o_busy;
  logic              o_ovr_flag;
  logic [OVR_W-1:0]  o_ovr_cnt;

  int checkCount;
  int errorCount;

  // Reference model: a line is described by the edge it started on and the
  // edge at which rendering was reported done, so the phase at any edge
  // follows from plain arithmetic on those two numbers.
  int edgeNo;
  bit mActive;
  int mStart;
  int mDoneAt;
  bit mLb;
  bit mFlag;
  int mCnt;

  cv_lbsched #(
    .ADDR_W   (ADDR_W),
    .LINE_PIX (LINE_PIX),
    .OVR_W    (OVR_W)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_enable      (i_enable),
    .i_frame_start (i_frame_start),
    .i_hstart      (i_hstart),
    .i_rend_line   (i_rend_line),
    .i_rd_done     (i_rd_done),
    .i_ovr_clr     (i_ovr_clr),
    .o_rd_cs       (o_rd_cs),
    .o_lb_sel      (o_lb_sel),
    .o_clr_we      (o_clr_we),
    .o_clr_addr    (o_clr_addr),
    .o_busy        (o_busy),
    .o_ovr_flag    (o_ovr_flag),
    .o_ovr_cnt     (o_ovr_cnt)
  );

  // Free-running 10 ns clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic int phaseAt(int t);
    if (!mActive) return PH_IDLE;
    if (t - mStart < LINE_PIX) return PH_CLEAR;
    if (t >= mDoneAt) return PH_HOLD;
    return PH_RENDER;
  endfunction

  task automatic modelReset();
    mActive = 1'b0;
    mStart  = 0;
    mDoneAt = NEVER;
    mLb     = 1'b0;
    mFlag   = 1'b0;
    mCnt    = 0;
  endtask

  task automatic modelEdge(bit en, bit fs, bit hs, bit rl, bit done, bit oc);
    int  p;
    bit  ovr;
    edgeNo++;
    p   = phaseAt(edgeNo - 1);
    ovr = en && hs && (p == PH_CLEAR || (p == PH_RENDER && !done));
    if (!en) begin
      mActive = 1'b0;
    end else if (hs) begin
      mActive = rl;
      mStart  = edgeNo;
      mDoneAt = NEVER;
    end else if (p == PH_RENDER && done) begin
      mDoneAt = edgeNo;
    end
    if (en) begin
      if (fs) mLb = 1'b0;
      else if (hs) mLb = !mLb;
    end
    if (ovr) begin
      mFlag = 1'b1;
      if (oc) mCnt = 1;
      else if (mCnt < CNT_MAX) mCnt = mCnt + 1;
    end else if (oc) begin
      mFlag = 1'b0;
      mCnt  = 0;
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s @edge %0d: got %0d, expected %0d", tag, edgeNo, observed, expected);
    end
  endtask

  task automatic compareAll();
    int p;
    p = phaseAt(edgeNo);
    checkOutput("clr_we",   32'(o_clr_we),   32'(p == PH_CLEAR));
    checkOutput("clr_addr", 32'(o_clr_addr), (p == PH_CLEAR) ? 32'(edgeNo - mStart) : 32'd0);
    checkOutput("rd_cs",    32'(o_rd_cs),    32'(p == PH_RENDER));
    checkOutput("busy",     32'(o_busy),     32'(p == PH_CLEAR || p == PH_RENDER));
    checkOutput("lb_sel",   32'(o_lb_sel),   32'(mLb));
    checkOutput("ovr_flag", 32'(o_ovr_flag), 32'(mFlag));
    checkOutput("ovr_cnt",  32'(o_ovr_cnt),  32'(mCnt));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare
  task automatic applyStimulus(bit en, bit fs, bit hs, bit rl, bit done, bit oc);
    i_enable      = en;
    i_frame_start = fs;
    i_hstart      = hs;
    i_rend_line   = rl;
    i_rd_done     = done;
    i_ovr_clr     = oc;
    @(posedge i_clk);
    modelEdge(en, fs, hs, rl, done, oc);
    #1;
    compareAll();
  endtask

  task automatic runCycles(int n, bit done);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, done, 1'b0);
  endtask

  initial begin
    int gap;
    bit rl;
    checkCount    = 0;
    errorCount    = 0;
    edgeNo        = 0;
    i_enable      = 1'b1;
    i_frame_start = 1'b0;
    i_hstart      = 1'b0;
    i_rend_line   = 1'b0;
    i_rd_done     = 1'b0;
    i_ovr_clr     = 1'b0;
    i_reset_n     = 1'b0;
    modelReset();

    // Reset state
    #12;
    checkOutput("reset_rd_cs",   32'(o_rd_cs),    32'd0);
    checkOutput("reset_clr_we",  32'(o_clr_we),   32'd0);
    checkOutput("reset_lb_sel",  32'(o_lb_sel),   32'd0);
    checkOutput("reset_ovr_cnt", 32'(o_ovr_cnt),  32'd0);
    compareAll();
    i_reset_n = 1'b1;
    @(posedge i_clk);
    edgeNo++;
    #1;

    // First line: swap, full clear, then render
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_lb_sel", 32'(o_lb_sel), 32'd1);
    runCycles(LINE_PIX - 1, 1'b0);
    checkOutput("t1_last_addr", 32'(o_clr_addr), 32'(LINE_PIX - 1));
    runCycles(1, 1'b0);
    checkOutput("t1_rd_cs", 32'(o_rd_cs), 32'd1);

    // Render completes after 50 cycles
    runCycles(49, 1'b0);
    runCycles(1, 1'b1);
    checkOutput("t2_rd_cs", 32'(o_rd_cs), 32'd0);
    checkOutput("t2_busy",  32'(o_busy),  32'd0);
    runCycles(5, 1'b0);

    // A line whose render never finishes, then the next hstart overruns it
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(LINE_PIX + 10, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_ovr_flag", 32'(o_ovr_flag), 32'd1);
    checkOutput("t3_ovr_cnt",  32'(o_ovr_cnt),  32'd1);
    checkOutput("t3_clr_addr", 32'(o_clr_addr), 32'd0);

    // Many back-to-back overruns saturate the counter
    for (int i = 0; i < 260; i++) begin
      runCycles(4, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("t4_sat", 32'(o_ovr_cnt), 32'(CNT_MAX));
    runCycles(3, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("t4_clr_with_ovr", 32'(o_ovr_cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_clr", 32'(o_ovr_cnt), 32'd0);

    // Skipped line goes idle; frame start realigns the buffer index
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runCycles(3, 1'b0);
    if (!mLb) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_lb_before", 32'(o_lb_sel), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_lb_after", 32'(o_lb_sel), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_fs_hs_lb", 32'(o_lb_sel), 32'd0);

    // Disable mid-clear, and hstart is ignored while disabled
    runCycles(10, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_clr_we",   32'(o_clr_we),   32'd0);
    checkOutput("t6_clr_addr", 32'(o_clr_addr), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_hs_ignored", 32'(o_clr_we), 32'd0);
    checkOutput("t6_lb_hold",    32'(o_lb_sel), 32'd0);

    // Asynchronous reset in the middle of a line
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    runCycles(20, 1'b0);
    #2;
    i_reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_clr_we", 32'(o_clr_we), 32'd0);
    compareAll();
    #1;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    i_enable = 1'b1;
    edgeNo++;
    #1;

    // Random line traffic
    gap = 0;
    for (int c = 0; c < 6000; c++) begin
      bit hs;
      hs = (gap == 0);
      if (hs) begin
        gap = $urandom_range(3, 450);
        rl  = ($urandom_range(0, 3) != 0);
      end else begin
        gap--;
        rl = 1'b0;
      end
      applyStimulus(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 299) == 0),
                    hs, rl,
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 399) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
